// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial N-bit two's-complement subtractor, diff = a - b, LSB first,
// one bit per clock. This is the inverse path to the serial adder and uses the
// same load / shift / result flow.
//
// Handshake: operands are accepted at an edge with in_valid=1 while in_ready=1.
// The result is presented with out_valid=1 and is released at an edge with
// out_ready=1.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready operand handshake
//   a, b                minuend / subtrahend (N bits, signed)
//   out_valid/out_ready result handshake
//   diff                a - b mod 2^N
//   borrow              1 when unsigned a < b
//   ovf                 signed overflow
//
// Optional feature, macro SERIAL_SUB_REF_EN:
//   adds diffk / borrowk (parallel reference from the captured operands) and
//   mismatch (1 in DONE when the serial and reference results disagree).
// -----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int unsigned N = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         borrow,
    output logic         ovf
`ifdef SERIAL_SUB_REF_EN
    ,
    output logic [N-1:0] diffk,
    output logic         borrowk,
    output logic         mismatch
`endif
);

    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q,     state_d;
    logic [N-1:0]       a_q,         a_d;
    logic [N-1:0]       b_q,         b_d;
    logic [N-1:0]       diff_q,      diff_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               br_q,        br_d;
    logic               a_msb_q,     a_msb_d;
    logic               b_msb_q,     b_msb_d;
    logic               borrow_q,    borrow_d;
    logic               ovf_q,       ovf_d;
    logic               in_ready_q,  in_ready_d;
    logic               out_valid_q, out_valid_d;

    // Full-subtractor cell for the current bit.
    logic bit_d_c;
    logic br_next_c;
    always_comb begin
        bit_d_c   = a_q[0] ^ b_q[0] ^ br_q;
        br_next_c = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    end

`ifdef SERIAL_SUB_REF_EN
    logic [N-1:0] diffk_q,    diffk_d;
    logic         borrowk_q,  borrowk_d;
    logic         mismatch_q, mismatch_d;
    logic [N:0]   ref_c;

    // Parallel reference of the same subtraction, taken at capture.
    always_comb begin
        ref_c = {1'b0, a} - {1'b0, b};
    end
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        diff_d      = diff_q;
        cnt_d       = cnt_q;
        br_d        = br_q;
        a_msb_d     = a_msb_q;
        b_msb_d     = b_msb_q;
        borrow_d    = borrow_q;
        ovf_d       = ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
`ifdef SERIAL_SUB_REF_EN
        diffk_d     = diffk_q;
        borrowk_d   = borrowk_q;
        mismatch_d  = mismatch_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d        = a;
                    b_d        = b;
                    a_msb_d    = a[N-1];
                    b_msb_d    = b[N-1];
                    br_d       = 1'b0;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = SHIFT;
`ifdef SERIAL_SUB_REF_EN
                    diffk_d    = ref_c[N-1:0];
                    borrowk_d  = ref_c[N];
`endif
                end
            end

            SHIFT: begin
                diff_d = {bit_d_c, diff_q[N-1:1]};
                a_d    = {1'b0, a_q[N-1:1]};
                b_d    = {1'b0, b_q[N-1:1]};
                br_d   = br_next_c;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    // The bit just produced becomes diff[N-1].
                    cnt_d       = cnt_q;
                    borrow_d    = br_next_c;
                    ovf_d       = (a_msb_q != b_msb_q) && (bit_d_c != a_msb_q);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
`ifdef SERIAL_SUB_REF_EN
                    mismatch_d  = ({br_next_c, bit_d_c, diff_q[N-1:1]} !=
                                   {borrowk_q, diffk_q});
`endif
                end
            end

            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
`ifdef SERIAL_SUB_REF_EN
                    mismatch_d  = 1'b0;
`endif
                end
            end

            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            diff_q      <= '0;
            cnt_q       <= '0;
            br_q        <= 1'b0;
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            borrow_q    <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef SERIAL_SUB_REF_EN
            diffk_q     <= '0;
            borrowk_q   <= 1'b0;
            mismatch_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            diff_q      <= diff_d;
            cnt_q       <= cnt_d;
            br_q        <= br_d;
            a_msb_q     <= a_msb_d;
            b_msb_q     <= b_msb_d;
            borrow_q    <= borrow_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef SERIAL_SUB_REF_EN
            diffk_q     <= diffk_d;
            borrowk_q   <= borrowk_d;
            mismatch_q  <= mismatch_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign borrow    = borrow_q;
    assign ovf       = ovf_q;
`ifdef SERIAL_SUB_REF_EN
    assign diffk     = diffk_q;
    assign borrowk   = borrowk_q;
    assign mismatch  = mismatch_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
// Directed-vector bench for serial_subtractor (N=64): a table of operand pairs
// with hand-computed diff/borrow/ovf, plus sequences for backpressure in DONE,
// reset in the middle of SHIFT, and recovery afterwards.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

    localparam int unsigned N = 64;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] diff;
    logic         borrow;
    logic         ovf;
`ifdef SERIAL_SUB_REF_EN
    logic [N-1:0] diffk;
    logic         borrowk;
    logic         mismatch;
`endif

    serial_subtractor #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .ovf       (ovf)
`ifdef SERIAL_SUB_REF_EN
        ,
        .diffk     (diffk),
        .borrowk   (borrowk),
        .mismatch  (mismatch)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] diff;
        logic         borrow;
        logic         ovf;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Present operands, wait for the result, check it, leave it held in DONE.
    task automatic start_and_wait(input vec_t v);
        int cycles;
        chk("in_ready_before_op", N'(in_ready), N'(1'b1));
        in_valid = 1'b1;
        a        = v.a;
        b        = v.b;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a        = {$urandom, $urandom};
        b        = {$urandom, $urandom};
        cycles   = 0;
        while (!out_valid && cycles < 4 * N) begin
            @(posedge clk);
            @(negedge clk);
            cycles++;
        end
        chk("latency", N'(cycles), N'(N));
        chk("diff", diff, v.diff);
        chk("borrow", N'(borrow), N'(v.borrow));
        chk("ovf", N'(ovf), N'(v.ovf));
        chk("in_ready_in_done", N'(in_ready), N'(1'b0));
`ifdef SERIAL_SUB_REF_EN
        chk("mismatch", N'(mismatch), N'(1'b0));
        chk("diffk", diffk, v.diff);
        chk("borrowk", N'(borrowk), N'(v.borrow));
`endif
    endtask

    // Release the held result and check it persists in IDLE.
    task automatic release_result(input vec_t v);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_after_release", N'(out_valid), N'(1'b0));
        chk("in_ready_after_release", N'(in_ready), N'(1'b1));
        chk("diff_held_in_idle", diff, v.diff);
    endtask

    vec_t vecs[8];
    vec_t v;

    initial begin
        vecs[0] = '{64'h0000_0000_0000_000F, 64'h0000_0000_0000_0004,
                    64'h0000_0000_0000_000B, 1'b0, 1'b0};
        vecs[1] = '{64'h0000_0000_0000_0002, 64'hFFFF_FFFF_FFFF_FFF6,
                    64'h0000_0000_0000_000C, 1'b1, 1'b0};
        vecs[2] = '{64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001,
                    64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1};
        vecs[3] = '{64'h0000_0000_0000_0000, 64'h8000_0000_0000_0000,
                    64'h8000_0000_0000_0000, 1'b1, 1'b1};
        vecs[4] = '{64'h1234_5678_9ABC_DEF0, 64'h0EFD_CBA9_8765_4321,
                    64'h0336_8ACF_1357_9BCF, 1'b0, 1'b0};
        vecs[5] = '{64'hDEAD_BEEF_0000_1234, 64'hDEAD_BEEF_0000_1234,
                    64'h0000_0000_0000_0000, 1'b0, 1'b0};
        vecs[6] = '{64'h0000_0000_0000_0000, 64'h0000_0000_0000_0001,
                    64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
        vecs[7] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                    64'h8000_0000_0000_0000, 1'b1, 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) @(negedge clk);
        chk("reset_in_ready", N'(in_ready), N'(1'b1));
        chk("reset_out_valid", N'(out_valid), N'(1'b0));
        chk("reset_diff", diff, '0);
        chk("reset_borrow", N'(borrow), N'(1'b0));
        chk("reset_ovf", N'(ovf), N'(1'b0));
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            start_and_wait(vecs[i]);
            release_result(vecs[i]);
        end

        // Backpressure: result held 5 cycles, new operands ignored.
        start_and_wait(vecs[4]);
        in_valid = 1'b1;
        a        = 64'h1111_1111_1111_1111;
        b        = 64'h2222_2222_2222_2222;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_out_valid", N'(out_valid), N'(1'b1));
            chk("bp_in_ready", N'(in_ready), N'(1'b0));
            chk("bp_diff", diff, vecs[4].diff);
            chk("bp_borrow", N'(borrow), N'(vecs[4].borrow));
            chk("bp_ovf", N'(ovf), N'(vecs[4].ovf));
        end
        // Release with in_valid still high: no capture on the DONE->IDLE edge.
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("bp_rel_out_valid", N'(out_valid), N'(1'b0));
        chk("bp_rel_in_ready", N'(in_ready), N'(1'b1));
        @(posedge clk);
        @(negedge clk);
        chk("bp_no_capture_in_ready", N'(in_ready), N'(1'b1));
        chk("bp_no_capture_diff", diff, vecs[4].diff);

        // Reset while SHIFT is working on bit 20.
        in_valid = 1'b1;
        a        = vecs[2].a;
        b        = vecs[2].b;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("mid_shift_in_ready", N'(in_ready), N'(1'b0));
        rst = 1'b1;
        #1;
        chk("rst_out_valid", N'(out_valid), N'(1'b0));
        chk("rst_in_ready", N'(in_ready), N'(1'b1));
        chk("rst_diff", diff, '0);
        chk("rst_borrow", N'(borrow), N'(1'b0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Recovery after the aborted operation.
        v = vecs[1];
        start_and_wait(v);
        release_result(v);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
